// File: rtl/tap_tempo_ctrl_if.sv
// rtl/tap_tempo_ctrl_if.sv - tap-tempo controller signal bundle
//
// Groups the tap input and the metronome-facing outputs of tap_tempo_ctrl.
//   tap      : debounced one-cycle tap pulse (master -> slave)
//   bpm_out  : 32-bit tempo presented to the metronome (slave -> master)
//   bpm_load : one-cycle load strobe for bpm_out (slave -> master)
//   tapping  : a tap sequence is open (slave -> master)
//   busy     : division in progress (slave -> master)
interface tap_tempo_ctrl_if;
  logic        tap;
  logic [31:0] bpm_out;
  logic        bpm_load;
  logic        tapping;
  logic        busy;

  modport master (
    output tap,
    input  bpm_out,
    input  bpm_load,
    input  tapping,
    input  busy
  );

  modport slave (
    input  tap,
    output bpm_out,
    output bpm_load,
    output tapping,
    output busy
  );
endinterface

// File: rtl/tap_tempo_ctrl.sv
// rtl/tap_tempo_ctrl.sv - tap-tempo to bpm controller with restoring divider
//
// Measures the dclk12 tick interval between taps, averages the two most
// recent intervals, divides TICKS_PER_MIN by it (one quotient bit per cycle)
// and loads the clamped result into the metronome.
//   dclk12   : single clock, all state changes on its rising edge
//   rst      : asynchronous active-high reset
//   bus      : slave side of tap_tempo_ctrl_if (tap in; bpm_out, bpm_load,
//              tapping, busy out)
module tap_tempo_ctrl #(
  parameter logic [31:0] TICKS_PER_MIN = 32'd732420,
  parameter logic [31:0] BPM_MIN       = 32'd40,
  parameter logic [31:0] BPM_MAX       = 32'd220,
  parameter logic [31:0] BPM_RESET     = 32'd88,
  parameter logic [31:0] TAP_TIMEOUT   = 32'd18311
) (
  input  logic            dclk12,
  input  logic            rst,
  tap_tempo_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    DIVIDE,
    LOAD
  } state_t;

  state_t      state;
  logic [31:0] counter;
  logic [31:0] prev;
  logic        prev_valid;
  logic [31:0] divisor;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [4:0]  iter;
  logic [31:0] bpm_q;
  logic        load_q;
  logic        tapping_q;
  logic        busy_q;

  logic [31:0] counter_inc;
  logic [32:0] avg_sum;
  logic [31:0] next_divisor;
  logic [32:0] rem_shift;
  logic        rem_ge;
  logic [31:0] rem_next;
  logic [31:0] bpm_clamped;

  always_comb begin
    // Counter saturates so a long silence never wraps into a bogus interval.
    counter_inc  = (counter >= TAP_TIMEOUT) ? counter : counter + 32'd1;

    // 33-bit sum keeps the carry before halving.
    avg_sum      = {1'b0, prev} + {1'b0, counter};
    next_divisor = prev_valid ? 32'(avg_sum >> 1) : counter;

    // Restoring step: quo doubles as the dividend shift register, so its MSB
    // is the next dividend bit and the new quotient bit enters at the LSB.
    rem_shift    = {rem, quo[31]};
    rem_ge       = (rem_shift >= {1'b0, divisor});
    rem_next     = rem_ge ? 32'(rem_shift - {1'b0, divisor}) : rem_shift[31:0];

    if (quo < BPM_MIN) begin
      bpm_clamped = BPM_MIN;
    end else if (quo > BPM_MAX) begin
      bpm_clamped = BPM_MAX;
    end else begin
      bpm_clamped = quo;
    end
  end

  always_ff @(posedge dclk12 or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      counter    <= 32'd0;
      prev       <= 32'd0;
      prev_valid <= 1'b0;
      divisor    <= 32'd1;
      rem        <= 32'd0;
      quo        <= 32'd0;
      iter       <= 5'd0;
      bpm_q      <= BPM_RESET;
      load_q     <= 1'b0;
      tapping_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      load_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.tap) begin
            state      <= ARMED;
            counter    <= 32'd1;
            prev_valid <= 1'b0;
            tapping_q  <= 1'b1;
          end
        end

        ARMED: begin
          // A tap on the timeout edge still counts as a valid interval.
          if (bus.tap) begin
            divisor    <= next_divisor;
            prev       <= counter;
            prev_valid <= 1'b1;
            counter    <= 32'd1;
            rem        <= 32'd0;
            quo        <= TICKS_PER_MIN;
            iter       <= 5'd0;
            state      <= DIVIDE;
            busy_q     <= 1'b1;
          end else if (counter >= TAP_TIMEOUT) begin
            state      <= IDLE;
            prev_valid <= 1'b0;
            tapping_q  <= 1'b0;
          end else begin
            counter    <= counter_inc;
          end
        end

        DIVIDE: begin
          // Taps are ignored here; the interval keeps running from the tap
          // that started this division.
          counter <= counter_inc;
          rem     <= rem_next;
          quo     <= {quo[30:0], rem_ge};
          iter    <= iter + 5'd1;
          if (iter == 5'd31) begin
            state  <= LOAD;
            busy_q <= 1'b0;
          end
        end

        LOAD: begin
          counter <= counter_inc;
          bpm_q   <= bpm_clamped;
          load_q  <= 1'b1;
          state   <= ARMED;
        end

        default: begin
          state     <= IDLE;
          tapping_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bpm_out  = bpm_q;
  assign bus.bpm_load = load_q;
  assign bus.tapping  = tapping_q;
  assign bus.busy     = busy_q;

endmodule
